pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 121 ++++++++++++
 tb/tb_pipelined_cla_adder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves one CHUNK-bit
// slice, and the stages advance together under a single valid/ready enable.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_sub,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             adv;
  logic             valid_reg;
  logic [WIDTH:0]   result_reg;
  logic             ovf_reg;

  // Per-stage inputs: x holds {unprocessed a slices, finished sum slices},
  // y holds the unprocessed b' slices, c is the carry into the stage's slice.
  logic             v_in [STAGES];
  logic [WIDTH-1:0] x_in [STAGES];
  logic [WIDTH-1:0] y_in [STAGES];
  logic             c_in [STAGES];

  assign adv      = i_ready || !valid_reg;
  assign o_ready  = adv;
  assign o_valid  = valid_reg;
  assign o_result = result_reg;
  assign o_ovf    = ovf_reg;

  // The mode is folded into b' and the slice-0 carry here, so it travels with the beat.
  assign v_in[0] = i_valid;
  assign x_in[0] = i_add1;
  assign y_in[0] = i_sub ? ~i_add2 : i_add2;
  assign c_in[0] = i_sub ? 1'b1 : i_carry;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * CHUNK;

    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] s;
    logic [CHUNK:0]   c;
    logic [WIDTH-1:0] x_next;

    assign a_s = x_in[gi][LO +: CHUNK];
    assign b_s = y_in[gi][LO +: CHUNK];
    assign g   = a_s & b_s;
    assign p   = a_s | b_s;

    always_comb begin
      c    = '0;
      c[0] = c_in[gi];
      for (int i = 0; i < CHUNK; i++) begin
        c[i+1] = g[i] | (p[i] & c[i]);
      end
    end

    assign s = a_s ^ b_s ^ c[CHUNK-1:0];

    always_comb begin
      x_next              = x_in[gi];
      x_next[LO +: CHUNK] = s;
    end

    if (gi < STAGES - 1) begin : g_mid
      // Finished b' slices are no longer needed downstream.
      localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} << (LO + CHUNK);

      logic             v_reg;
      logic [WIDTH-1:0] x_reg;
      logic [WIDTH-1:0] y_reg;
      logic             c_reg;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          v_reg <= 1'b0;
          x_reg <= '0;
          y_reg <= '0;
          c_reg <= 1'b0;
        end else if (adv) begin
          v_reg <= v_in[gi];
          x_reg <= x_next;
          y_reg <= y_in[gi] & KEEP_MASK;
          c_reg <= c[CHUNK];
        end
      end

      assign v_in[gi+1] = v_reg;
      assign x_in[gi+1] = x_reg;
      assign y_in[gi+1] = y_reg;
      assign c_in[gi+1] = c_reg;
    end else begin : g_last
      // Overflow compares the carry into the MSB with the carry out of it.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          valid_reg  <= 1'b0;
          result_reg <= '0;
          ovf_reg    <= 1'b0;
        end else if (adv) begin
          valid_reg  <= v_in[gi];
          result_reg <= {c[CHUNK], x_next};
          ovf_reg    <= c[CHUNK] ^ c[CHUNK-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=16, CHUNK=4): arithmetic reference model,
// a per-cycle compare process, and directed, mixed, reset and stall scenarios.
module tb_pipelined_cla_adder;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_add1;
  logic [15:0] i_add2;
  logic        i_sub;
  logic        i_carry;
  logic        o_valid;
  logic        i_ready;
  logic [16:0] o_result;
  logic        o_ovf;

  pipelined_cla_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_add1  (i_add1),
    .i_add2  (i_add2),
    .i_sub   (i_sub),
    .i_carry (i_carry),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_ovf   (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          pops  = 0;
  int          cyc   = 0;
  logic        timing_on = 1'b0;
  logic        stalled   = 1'b0;
  logic [17:0] held;
  logic [17:0] e_val;
  logic [17:0] exp_q [$];
  logic        hist [64];
  logic [15:0] st_a [20];
  logic [15:0] st_b [20];
  logic        st_s [20];
  logic        st_c [20];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  // {ovf, carry/no-borrow, 16-bit sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic cin);
    int          sa;
    int          sb;
    int          sr;
    logic [16:0] r;
    logic        ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r[15:0] = a - b;
      r[16]   = (a >= b);
      sr      = sa - sb;
    end else begin
      r  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      sr = sa + sb + int'(cin);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, r};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (i_rst) begin
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_o_ready", 32'(o_ready), 32'd1);
      check("rst_o_result", 32'(o_result), 32'd0);
      check("rst_o_ovf", 32'(o_ovf), 32'd0);
      exp_q.delete();
      foreach (hist[i]) hist[i] = 1'b0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_hold", 32'(o_valid), 32'd1);
        check("stall_result_hold", 32'({o_ovf, o_result}), 32'(held));
      end
      if (timing_on)
        check("valid_timing", 32'(o_valid), 32'(hist[(cyc - 4) & 63]));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_beat: got beat 0x%0h, expected no beat", {o_ovf, o_result});
        end else begin
          e_val = exp_q.pop_front();
          check("result", 32'({o_ovf, o_result}), 32'(e_val));
          pops++;
        end
      end
      stalled = o_valid && !i_ready;
      held    = {o_ovf, o_result};
      hist[cyc & 63] = i_valid && o_ready;
      if (i_valid && o_ready)
        exp_q.push_back(model(i_add1, i_add2, i_sub, i_carry));
    end
  end

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; sends one beat and measures its latency.
  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin,
                          input logic [16:0] exp_r, input logic exp_o);
    int lat;
    check({name, "_model"}, 32'(model(a, b, sub, cin)), 32'({exp_o, exp_r}));
    i_valid = 1'b1;
    i_add1  = a;
    i_add2  = b;
    i_sub   = sub;
    i_carry = cin;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd4);
    check({name, "_result"}, 32'(o_result), 32'(exp_r));
    check({name, "_ovf"}, 32'(o_ovf), 32'(exp_o));
  endtask

  initial begin
    int idx;
    int k;
    int pops_start;
    logic acc;

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_add1  = '0;
    i_add2  = '0;
    i_sub   = 1'b0;
    i_carry = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    idle(5);
    timing_on = 1'b1;

    directed("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0);
    directed("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b0, 17'h0FFFE, 1'b0);
    directed("sub_pos",  16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002, 1'b0);
    directed("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1);
    directed("ovf_sub",  16'h8000, 16'h0001, 1'b1, 1'b0, 17'h17FFF, 1'b1);
    directed("carry_in", 16'h0000, 16'h0000, 1'b0, 1'b1, 17'h00001, 1'b0);
    idle(5);

    // Alternating modes with random bubbles; i_ready stays high.
    for (int m = 0; m < 24; m++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_sub   = (m % 2) == 1;
      i_add1  = 16'($urandom);
      i_add2  = 16'($urandom);
      i_carry = 1'($urandom);
      @(posedge clk);
      #1;
    end
    idle(6);

    // Reset with three beats in flight, the oldest already at the output.
    for (int m = 0; m < 3; m++) begin
      i_valid = 1'b1;
      i_sub   = 1'($urandom);
      i_add1  = 16'($urandom);
      i_add2  = 16'($urandom);
      i_carry = 1'($urandom);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_pre_valid", 32'(o_valid), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(o_valid), 32'd0);
    check("rst_async_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    directed("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0);
    idle(8);
    check("rst_discard", 32'(exp_q.size()), 32'd0);

    // 20 back-to-back beats with downstream stalled for cycles 6-8.
    timing_on = 1'b0;
    for (int m = 0; m < 20; m++) begin
      st_a[m] = 16'($urandom);
      st_b[m] = 16'($urandom);
      st_s[m] = 1'($urandom);
      st_c[m] = 1'($urandom);
    end
    pops_start = pops;
    idx = 0;
    k = 0;
    while (idx < 20 && k < 200) begin
      i_ready = !(k >= 6 && k <= 8);
      i_valid = 1'b1;
      i_add1  = st_a[idx];
      i_add2  = st_b[idx];
      i_sub   = st_s[idx];
      i_carry = st_c[idx];
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      k++;
    end
    check("stream_sent", 32'(idx), 32'd20);
    i_valid = 1'b0;
    i_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    idle(2);
    check("stream_drain", 32'(exp_q.size()), 32'd0);
    check("stream_count", 32'(pops - pops_start), 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
